sound_out_decim: RTL and testbench
==================================

Name: sound_out_decim

Overview:
- Downstream stage of the sound mixer. Consumes the mixed 16-bit stereo sample stream, which updates every clk, and applies a one-pole low-pass anti-alias filter per channel.
- Decimates the filtered stream to a fixed output rate using a fractional tick generator driven by the run-time clock rate.
- Buffers the decimated frames in a small show-ahead FIFO with a valid/ready handshake toward the audio output path.

Parameters:
- OUT_RATE, 48000, output sample rate in Hz.
- FIFO_AW, 3, log2 of FIFO depth (default 8 frames).
- LPF_SHIFT, 4, filter coefficient exponent (alpha = 2^-LPF_SHIFT).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- clock_rate  in  28  clk frequency in Hz; may change at run time.
- sample_l_in  in  16  signed mixed left sample, sampled every clk.
- sample_r_in  in  16  signed mixed right sample, sampled every clk.
- mute  in  1  forces captured frames to 0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head frame.
- out_l  out  16  signed head-of-FIFO left sample.
- out_r  out  16  signed head-of-FIFO right sample.
- level  out  FIFO_AW+1  current FIFO occupancy.
- overrun  out  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset is synchronous, active-low, on rst_n, clocked by clk. It clears:
  - all accumulators, the tick sum and the FIFO pointers;
  - out_valid=0, level=0, overrun=0, out_l=out_r=0.
  - FIFO storage contents are don't-care; out_l/out_r read 0 while the FIFO is empty.
- clock_rate is registered once (clk_rate) before use. A change of clock_rate takes effect 1 cycle later.
- Tick generator, each cycle:
  - sum <= sum + OUT_RATE;
  - if (sum + OUT_RATE) >= clk_rate then sum <= sum + OUT_RATE - clk_rate and tick=1.
  - If clk_rate==0: tick is held 0 and sum is held 0.
  - Ticks never occur in two consecutive cycles while clk_rate > 2*OUT_RATE.
- Low-pass filter, per channel:
  - acc is a signed register of 16+LPF_SHIFT+1 bits.
  - acc <= acc + sext(in) - (acc >>> LPF_SHIFT), where >>> is an arithmetic (floor) shift.
  - filt = (acc >>> LPF_SHIFT)[15:0].
  - DC gain is exactly 1: for constant input x, filt converges exactly to x. The acc width guarantees no overflow for any 16-bit input.
- Capture: on a tick cycle the frame {filt_l, filt_r} is pushed, or {0,0} when mute=1. The frame uses the acc value registered before this cycle's update.
- FIFO:
  - 2^FIFO_AW entries; read/write pointers FIFO_AW+1 bits wide, wrapping naturally.
  - full = level == 2^FIFO_AW; empty = level == 0.
  - Show-ahead: out_l/out_r present the head entry combinationally from storage whenever out_valid=1.
  - Pop when out_valid & out_ready. out_ready while empty is ignored.
  - Push when tick & (~full | pop). If full and popping in the same cycle, both occur and level stays at 2^FIFO_AW.
  - When tick & full & ~pop: the frame is dropped, contents and pointers are unchanged, and overrun=1 on the next cycle only.
  - level is updated by +1 / -1 / 0 for push-only / pop-only / both-or-neither.
- Latency: tick in cycle T into an empty FIFO gives out_valid=1 at cycle T+1 with that frame on out_l/out_r.
- out_valid stays high, with the head frame stable, until it is popped; there is no withdrawal.
- Reset mid-operation: all buffered frames are discarded and out_valid falls on the cycle after rst_n is sampled low.
- mute does not affect the filter state; it affects only the captured value.

Test Plan:
- Tick spacing: clock_rate=480000, OUT_RATE=48000, out_ready=1 -> exactly one push every 10 cycles; level never exceeds 1; out_valid is a 1-cycle pulse per 10 cycles.
- Step response: sample_l_in=16'h4000, sample_r_in=16'hC000 for 2000 cycles -> out_l==16'h4000 and out_r==16'hC000 exactly; first pushed frames are monotonic increasing (left) and decreasing (right).
- Overrun: out_ready=0, constant input -> level reaches 8 after 8 ticks; 9th tick -> overrun pulses 1 cycle, level stays 8, head frame unchanged; then out_ready=1 drains 8 frames in order.
- Simultaneous push/pop at full: level=8, out_ready=1 on a tick cycle -> level remains 8, no overrun, new frame appears at tail.
- Mute and zero rate: mute=1 with input 16'h7FFF -> captured frames 0; clock_rate=0 -> no pushes for 1000 cycles; restoring the rate resumes ticks within 1 output period.
- Reset mid-stream: assert rst_n=0 for 1 cycle with level=5 -> next cycle level=0, out_valid=0, overrun=0; filter restarts from 0.

Source files
------------

// File: rtl/sound_out_decim.sv
// Anti-alias low-pass, fractional-rate decimator and show-ahead output FIFO
// sitting between the sound mixer and the audio output path.
`timescale 1ns/1ps
module sound_out_decim #(
    parameter int OUT_RATE  = 48000,
    parameter int FIFO_AW   = 3,
    parameter int LPF_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [27:0]        clock_rate,
    input  logic signed [15:0] sample_l_in,
    input  logic signed [15:0] sample_r_in,
    input  logic               mute,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_l,
    output logic signed [15:0] out_r,
    output logic [FIFO_AW:0]   level,
    output logic               overrun
);
    localparam int ACC_W = 16 + LPF_SHIFT + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;
    localparam logic [FIFO_AW:0] LVL_FULL = DEPTH[FIFO_AW:0];

    logic [27:0] r_clk_rate;
    logic [27:0] r_sum;
    logic [28:0] w_sum_inc;
    logic        w_tick;

    // One extra bit so sum + OUT_RATE never wraps before the compare.
    assign w_sum_inc = {1'b0, r_sum} + 29'(OUT_RATE);
    assign w_tick    = (r_clk_rate != '0) && (w_sum_inc >= {1'b0, r_clk_rate});

    logic        [1:0][15:0] w_in;
    logic signed [ACC_W-1:0] r_acc     [2];
    logic signed [ACC_W-1:0] w_ext     [2];
    logic signed [ACC_W-1:0] w_shr     [2];
    logic signed [ACC_W-1:0] w_acc_nxt [2];
    logic        [1:0][15:0] w_filt;

    assign w_in[0] = sample_l_in;
    assign w_in[1] = sample_r_in;

    // Kept in separate signed nets so the shift stays arithmetic.
    for (genvar c = 0; c < 2; c++) begin : g_ch
        assign w_ext[c]     = {{(ACC_W-16){w_in[c][15]}}, w_in[c]};
        assign w_shr[c]     = r_acc[c] >>> LPF_SHIFT;
        assign w_acc_nxt[c] = r_acc[c] + w_ext[c] - w_shr[c];
        assign w_filt[c]    = w_shr[c][15:0];
    end

    logic [31:0]      w_frame;
    logic [31:0]      r_mem [DEPTH];
    logic [FIFO_AW:0] r_wptr, r_rptr, r_level;
    logic             r_overrun;
    logic             w_full, w_empty, w_pop, w_push;
    logic [31:0]      w_head;

    assign w_frame = mute ? 32'h0 : {w_filt[0], w_filt[1]};
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    assign w_pop   = ~w_empty & out_ready;
    assign w_push  = w_tick & (~w_full | w_pop);
    assign w_head  = r_mem[r_rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= w_frame;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_rate <= '0;
            r_sum      <= '0;
            r_acc[0]   <= '0;
            r_acc[1]   <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_clk_rate <= clock_rate;
            if (r_clk_rate == '0)
                r_sum <= '0;
            else if (w_tick)
                r_sum <= 28'(w_sum_inc - {1'b0, r_clk_rate});
            else
                r_sum <= 28'(w_sum_inc);
            for (int c = 0; c < 2; c++) r_acc[c] <= w_acc_nxt[c];
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + PTR_ONE;
                2'b01:   r_level <= r_level - PTR_ONE;
                default: r_level <= r_level;
            endcase
            r_overrun <= w_tick & w_full & ~w_pop;
        end
    end

    assign out_valid = ~w_empty;
    assign out_l     = out_valid ? w_head[31:16] : 16'sh0;
    assign out_r     = out_valid ? w_head[15:0]  : 16'sh0;
    assign level     = r_level;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_sound_out_decim.sv
// Bench for sound_out_decim: per-cycle comparison against a queue-based
// reference model, a constant-input vector table and directed corner sequences.
`timescale 1ns/1ps
module tb_sound_out_decim;
    localparam int OUT_RATE  = 48000;
    localparam int FIFO_AW   = 3;
    localparam int LPF_SHIFT = 4;
    localparam int DEPTH     = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [27:0]        clock_rate;
    logic signed [15:0] sample_l_in, sample_r_in;
    logic               mute, out_ready;
    logic               out_valid, overrun;
    logic signed [15:0] out_l, out_r;
    logic [FIFO_AW:0]   level;

    always #5 clk = ~clk;

    sound_out_decim #(.OUT_RATE(OUT_RATE), .FIFO_AW(FIFO_AW), .LPF_SHIFT(LPF_SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .clock_rate(clock_rate),
        .sample_l_in(sample_l_in), .sample_r_in(sample_r_in), .mute(mute),
        .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_r(out_r),
        .level(level), .overrun(overrun)
    );

    typedef struct { logic [15:0] l; logic [15:0] r; } frame_t;
    typedef struct { logic [15:0] l; logic [15:0] r; bit mu; logic [15:0] el; logic [15:0] er; } vec_t;

    // Reference model state
    frame_t  mq[$];
    longint  msum, mrate;
    int      macc_l, macc_r;
    bit      movr;

    int errors = 0;
    int checks = 0;

    vec_t               tbl[5];
    frame_t             snap[$];
    frame_t             hd;
    logic signed [15:0] fl[$], fr[$];
    int                 nv, mx, k;
    int unsigned        rates[7] = '{480000, 96001, 144000, 1000000, 50000, 0, 100000};

    function automatic void check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit m_tick();
        return (mrate != 0) && (msum + OUT_RATE >= mrate);
    endfunction

    task automatic model_edge();
        frame_t f;
        bit tk, pop, full;
        if (!rst_n) begin
            msum = 0; mrate = 0; macc_l = 0; macc_r = 0; movr = 0;
            mq.delete();
        end else begin
            tk   = m_tick();
            f.l  = mute ? 16'h0 : 16'(macc_l >>> LPF_SHIFT);
            f.r  = mute ? 16'h0 : 16'(macc_r >>> LPF_SHIFT);
            pop  = (mq.size() > 0) && out_ready;
            full = (mq.size() == DEPTH);
            movr = tk && full && !pop;
            if (pop) void'(mq.pop_front());
            if (tk && (!full || pop)) mq.push_back(f);
            if (mrate == 0)  msum = 0;
            else if (tk)     msum = msum + OUT_RATE - mrate;
            else             msum = msum + OUT_RATE;
            macc_l = macc_l + int'(sample_l_in) - (macc_l >>> LPF_SHIFT);
            macc_r = macc_r + int'(sample_r_in) - (macc_r >>> LPF_SHIFT);
            mrate  = longint'(clock_rate);
        end
    endtask

    task automatic step();
        frame_t h;
        logic [37:0] exp_v, act_v;
        @(posedge clk);
        model_edge();
        #1;
        h.l = 16'h0; h.r = 16'h0;
        if (mq.size() > 0) h = mq[0];
        exp_v = {mq.size() != 0, 4'(mq.size()), h.l, h.r, movr};
        act_v = {out_valid, level, out_l, out_r, overrun};
        check("cycle{valid,level,l,r,ovr}", act_v, exp_v);
    endtask

    task automatic wait_level(input int n, input int bound, input string nm);
        int c = 0;
        while (level != n && c < bound) begin step(); c++; end
        check(nm, level, n);
    endtask

    initial begin
        tbl[0] = '{16'h4000, 16'hC000, 1'b0, 16'h4000, 16'hC000};
        tbl[1] = '{16'h7FFF, 16'h8000, 1'b0, 16'h7FFF, 16'h8000};
        tbl[2] = '{16'h0123, 16'hFEDC, 1'b0, 16'h0123, 16'hFEDC};
        tbl[3] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'h0000, 16'h0000};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 16'h8000, 16'h0001};

        rst_n = 1'b0; clock_rate = 28'd480000; sample_l_in = '0; sample_r_in = '0;
        mute = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        check("reset_valid", out_valid, 0);
        check("reset_level", level, 0);
        check("reset_ovr", overrun, 0);
        check("reset_out_l", {out_l}, 0);
        rst_n = 1'b1;

        // Step response from a cleared filter: first frames move monotonically
        sample_l_in = 16'sh4000; sample_r_in = -16'sh4000; out_ready = 1'b1;
        for (int i = 0; i < 100 && fl.size() < 5; i++) begin
            step();
            if (out_valid) begin fl.push_back(out_l); fr.push_back(out_r); end
        end
        check("mono_count", fl.size(), 5);
        for (int i = 1; i < fl.size(); i++) begin
            check("mono_l_rise", fl[i] > fl[i-1], 1);
            check("mono_r_fall", fr[i] < fr[i-1], 1);
        end

        // 480 kHz / 48 kHz: one frame every 10 cycles, drained immediately
        nv = 0; mx = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            nv += int'(out_valid);
            if (int'(level) > mx) mx = int'(level);
        end
        check("tick_spacing", nv, 10);
        check("tick_max_level", mx, 1);

        // Converged constant-input table (incl. mute)
        for (int i = 0; i < 5; i++) begin
            sample_l_in = tbl[i].l; sample_r_in = tbl[i].r; mute = tbl[i].mu;
            repeat (2000) step();
            k = 0;
            while (!out_valid && k < 20) begin step(); k++; end
            check("vec_valid", out_valid, 1);
            check("vec_l", {out_l}, tbl[i].el);
            check("vec_r", {out_r}, tbl[i].er);
        end
        mute = 1'b0;

        // Overrun: fill, drop one, then drain in order
        sample_l_in = 16'sh1111; sample_r_in = 16'sh2222; out_ready = 1'b0;
        wait_level(8, 200, "ovr_fill");
        hd.l = 16'h0; hd.r = 16'h0;
        if (mq.size() > 0) hd = mq[0];
        k = 0;
        while (!overrun && k < 20) begin step(); k++; end
        check("ovr_pulse", overrun, 1);
        check("ovr_level", level, 8);
        check("ovr_head", {out_l}, hd.l);
        step();
        check("ovr_one_cycle", overrun, 0);
        snap = mq;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && i < snap.size(); i++) begin
            check("drain_l", {out_l}, snap[i].l);
            check("drain_r", {out_r}, snap[i].r);
            step();
        end

        // Push and pop together while full
        out_ready = 1'b0;
        wait_level(8, 200, "full_fill");
        k = 0;
        while (!m_tick() && k < 20) begin step(); k++; end
        snap = mq;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("full_pp_level", level, 8);
        check("full_pp_ovr", overrun, 0);
        if (snap.size() > 1) check("full_pp_head", {out_l}, snap[1].l);
        out_ready = 1'b1;
        repeat (100) step();

        // Zero rate halts ticks; restoring it resumes within one period
        clock_rate = 28'd0;
        repeat (3) step();
        nv = 0;
        repeat (1000) begin step(); nv += int'(out_valid); end
        check("zero_rate_pushes", nv, 0);
        clock_rate = 28'd480000;
        k = 0;
        while (!out_valid && k < 12) begin step(); k++; end
        check("rate_resume", out_valid, 1);

        // Reset mid-stream with frames buffered
        out_ready = 1'b0;
        wait_level(5, 100, "rst_fill");
        rst_n = 1'b0;
        step();
        check("midrst_level", level, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_ovr", overrun, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (50) step();

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            sample_l_in = 16'($urandom);
            sample_r_in = 16'($urandom);
            mute        = ($urandom_range(7) == 0);
            out_ready   = 1'($urandom_range(1));
            if (c % 250 == 0) clock_rate = 28'(rates[$urandom_range(6)]);
            rst_n       = ($urandom_range(499) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
